// File: rtl/regfile_mp.sv
// Two-write/two-read register file with byte enables, optional same-cycle
// write forwarding and a per-register pending-write scoreboard.
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    RegWr0,
  input  logic [ADDR_WIDTH-1:0]   Rw0,
  input  logic [DATA_WIDTH-1:0]   busW0,
  input  logic [DATA_WIDTH/8-1:0] ByteEn0,
  input  logic                    RegWr1,
  input  logic [ADDR_WIDTH-1:0]   Rw1,
  input  logic [DATA_WIDTH-1:0]   busW1,
  input  logic [DATA_WIDTH/8-1:0] ByteEn1,
  input  logic [ADDR_WIDTH-1:0]   Ra,
  input  logic [ADDR_WIDTH-1:0]   Rb,
  output logic [DATA_WIDTH-1:0]   busA,
  output logic [DATA_WIDTH-1:0]   busB,
  input  logic                    Rset_en,
  input  logic [ADDR_WIDTH-1:0]   Rset,
  output logic                    busyA,
  output logic                    busyB
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs     [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_nxt [NUM_REGS];
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_nxt;
  logic [NUM_REGS-1:0]   wr0_hit;
  logic [NUM_REGS-1:0]   wr1_hit;
  logic [NUM_REGS-1:0]   set_hit;
  logic [NUM_REGS-1:0]   clr_hit;

  function automatic logic writable(input int r);
    return !((ZERO_REG != 0) && (r == 0));
  endfunction

  // Hits are gated by rst_n so reset also suppresses forwarding; addresses
  // at or above NUM_REGS match no register and fall out naturally.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      wr0_hit[r] = rst_n && RegWr0 && (Rw0 == ADDR_WIDTH'(r)) && writable(r);
      wr1_hit[r] = rst_n && RegWr1 && (Rw1 == ADDR_WIDTH'(r)) && writable(r);
      set_hit[r] = rst_n && Rset_en && (Rset == ADDR_WIDTH'(r)) && writable(r);
      clr_hit[r] = (wr0_hit[r] && (|ByteEn0)) || (wr1_hit[r] && (|ByteEn1));
      pending_nxt[r] = set_hit[r] || (pending[r] && !clr_hit[r]);
      regs_nxt[r] = regs[r];
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr0_hit[r] && ByteEn0[i]) regs_nxt[r][8*i +: 8] = busW0[8*i +: 8];
        // Port 1 applied last so it wins overlapping bytes.
        if (wr1_hit[r] && ByteEn1[i]) regs_nxt[r][8*i +: 8] = busW1[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      pending <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= regs_nxt[r];
      pending <= pending_nxt;
    end
  end

  // A busy flag is masked only by a clearing write with no competing set.
  always_comb begin
    busA  = '0;
    busB  = '0;
    busyA = 1'b0;
    busyB = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (Ra == ADDR_WIDTH'(r)) begin
        busA  = (BYPASS != 0) ? regs_nxt[r] : regs[r];
        busyA = (BYPASS != 0) ? (pending[r] && !(clr_hit[r] && !set_hit[r])) : pending[r];
      end
      if (Rb == ADDR_WIDTH'(r)) begin
        busB  = (BYPASS != 0) ? regs_nxt[r] : regs[r];
        busyB = (BYPASS != 0) ? (pending[r] && !(clr_hit[r] && !set_hit[r])) : pending[r];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: forwarding, non-forwarding and 24-register instances
// share one stimulus; expectations queue up at drive time and drain at sample.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWr0, RegWr1, Rset_en;
  logic [4:0]  Rw0, Rw1, Ra, Rb, Rset;
  logic [31:0] busW0, busW1;
  logic [3:0]  ByteEn0, ByteEn1;

  logic [31:0] busA_b, busB_b, busA_nb, busB_nb, busA_z, busB_z;
  logic        busyA_b, busyB_b, busyA_nb, busyB_nb, busyA_z, busyB_z;

  localparam int S_A_B = 0, S_B_B = 1, S_YA_B = 2, S_YB_B = 3;
  localparam int S_A_NB = 4, S_YA_NB = 5;
  localparam int S_A_Z = 6, S_B_Z = 7, S_YA_Z = 8, S_YB_Z = 9;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .RegWr0(RegWr0), .Rw0(Rw0), .busW0(busW0), .ByteEn0(ByteEn0),
    .RegWr1(RegWr1), .Rw1(Rw1), .busW1(busW1), .ByteEn1(ByteEn1),
    .Ra(Ra), .Rb(Rb), .busA(busA_b), .busB(busB_b),
    .Rset_en(Rset_en), .Rset(Rset), .busyA(busyA_b), .busyB(busyB_b));

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .RegWr0(RegWr0), .Rw0(Rw0), .busW0(busW0), .ByteEn0(ByteEn0),
    .RegWr1(RegWr1), .Rw1(Rw1), .busW1(busW1), .ByteEn1(ByteEn1),
    .Ra(Ra), .Rb(Rb), .busA(busA_nb), .busB(busB_nb),
    .Rset_en(Rset_en), .Rset(Rset), .busyA(busyA_nb), .busyB(busyB_nb));

  regfile_mp #(.NUM_REGS(24), .BYPASS(1)) dut_z (
    .clk(clk), .rst_n(rst_n),
    .RegWr0(RegWr0), .Rw0(Rw0), .busW0(busW0), .ByteEn0(ByteEn0),
    .RegWr1(RegWr1), .Rw1(Rw1), .busW1(busW1), .ByteEn1(ByteEn1),
    .Ra(Ra), .Rb(Rb), .busA(busA_z), .busB(busB_z),
    .Rset_en(Rset_en), .Rset(Rset), .busyA(busyA_z), .busyB(busyB_z));

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_A_B:   return busA_b;
      S_B_B:   return busB_b;
      S_YA_B:  return {31'd0, busyA_b};
      S_YB_B:  return {31'd0, busyB_b};
      S_A_NB:  return busA_nb;
      S_YA_NB: return {31'd0, busyA_nb};
      S_A_Z:   return busA_z;
      S_B_Z:   return busB_z;
      S_YA_Z:  return {31'd0, busyA_z};
      S_YB_Z:  return {31'd0, busyB_z};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic expect_out(input string tag, input int sel, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.sel = sel; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      check_val(x.tag, obs(x.sel), x.exp);
    end
  endtask

  task automatic idle();
    RegWr0 = 0; Rw0 = 0; busW0 = 0; ByteEn0 = 0;
    RegWr1 = 0; Rw1 = 0; busW1 = 0; ByteEn1 = 0;
    Rset_en = 0; Rset = 0; Ra = 0; Rb = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    RegWr0 = 1; Rw0 = a; busW0 = d; ByteEn0 = be;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    RegWr1 = 1; Rw1 = a; busW1 = d; ByteEn1 = be;
  endtask

  logic [31:0] m [32];
  logic [31:0] mn [32];
  logic [31:0] pend;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    expect_out("rst_busA", S_A_B, 0);
    expect_out("rst_busB", S_B_B, 0);
    expect_out("rst_busyA", S_YA_B, 0);
    expect_out("rst_busyB", S_YB_B, 0);
    drain();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Preload r5 and mark it pending, then pulse reset mid-cycle.
    wr0(5, 32'hDEADBEEF, 4'hF); Rset_en = 1; Rset = 5; Ra = 5;
    expect_out("byp_r5", S_A_B, 32'hDEADBEEF);
    expect_out("nobyp_r5_old", S_A_NB, 0);
    drain();
    next_cycle();
    Ra = 5;
    expect_out("r5_stored", S_A_NB, 32'hDEADBEEF);
    expect_out("r5_busy", S_YA_B, 1);
    drain();
    rst_n = 1'b0;
    expect_out("async_rst_busA", S_A_B, 0);
    expect_out("async_rst_busyA", S_YA_B, 0);
    expect_out("async_rst_busA_nb", S_A_NB, 0);
    expect_out("async_rst_busyA_nb", S_YA_NB, 0);
    drain();
    wr0(6, 32'h0000AAAA, 4'hF); Rset_en = 1; Rset = 6; Ra = 6;
    expect_out("rst_no_bypass", S_A_B, 0);
    expect_out("rst_no_busy", S_YA_B, 0);
    drain();
    next_cycle();
    rst_n = 1'b1;
    Ra = 6;
    expect_out("rst_wr_ignored", S_A_NB, 0);
    expect_out("rst_set_ignored", S_YA_NB, 0);
    drain();

    // Byte merge
    wr0(3, 32'h11223344, 4'hF);
    drain();
    next_cycle();
    wr0(3, 32'hAABBCCDD, 4'b0101); Ra = 3;
    expect_out("merge_byp", S_A_B, 32'h11BB33DD);
    expect_out("merge_old", S_A_NB, 32'h11223344);
    drain();
    next_cycle();
    Ra = 3; Rb = 3;
    expect_out("merge_stored", S_A_NB, 32'h11BB33DD);
    expect_out("merge_busB", S_B_B, 32'h11BB33DD);
    drain();

    // Collision: port 1 wins on overlapping low bytes
    wr0(7, 32'hFFFFFFFF, 4'hF); wr1(7, 32'h00000000, 4'b0011); Ra = 7;
    expect_out("coll_byp", S_A_B, 32'hFFFF0000);
    drain();
    next_cycle();
    Ra = 7;
    expect_out("coll_stored", S_A_NB, 32'hFFFF0000);
    drain();

    // Bypass timing
    wr0(9, 32'h12345678, 4'hF); Ra = 9; Rb = 3;
    expect_out("byp_same_cycle", S_A_B, 32'h12345678);
    expect_out("nobyp_old", S_A_NB, 0);
    expect_out("byp_busB_other", S_B_B, 32'h11BB33DD);
    drain();
    next_cycle();
    Ra = 9;
    expect_out("nobyp_next", S_A_NB, 32'h12345678);
    drain();

    // Scoreboard
    Rset_en = 1; Rset = 4; Ra = 4;
    expect_out("sb_set_not_yet", S_YA_B, 0);
    drain();
    next_cycle();
    Ra = 4;
    expect_out("sb_set_vis_nb", S_YA_NB, 1);
    wr0(4, 32'h1, 4'hF); Rset_en = 1; Rset = 4;
    expect_out("sb_set_wins_byp", S_YA_B, 1);
    drain();
    next_cycle();
    Ra = 4;
    expect_out("sb_still_busy", S_YA_NB, 1);
    wr0(4, 32'h2, 4'hF);
    expect_out("sb_clr_byp", S_YA_B, 0);
    expect_out("sb_clr_nobyp", S_YA_NB, 1);
    drain();
    next_cycle();
    Ra = 4;
    expect_out("sb_cleared", S_YA_NB, 0);
    Rset_en = 1; Rset = 8;
    drain();
    next_cycle();
    wr0(8, 32'h55, 4'h0); Rb = 8;
    expect_out("sb_be0_noclr_byp", S_YB_B, 1);
    drain();
    next_cycle();
    Rb = 8;
    expect_out("sb_be0_noclr", S_YB_B, 1);
    drain();

    // Zero register / out-of-range on the 24-entry instance
    wr0(0, 32'd5, 4'hF); wr1(30, 32'd7, 4'hF); Rset_en = 1; Rset = 0; Ra = 0; Rb = 30;
    expect_out("z_r0_byp", S_A_Z, 0);
    expect_out("z_r30_byp", S_B_Z, 0);
    expect_out("z_r0_busy", S_YA_Z, 0);
    expect_out("z_r0_byp_b", S_A_B, 0);
    drain();
    next_cycle();
    Ra = 0; Rb = 30; Rset_en = 1; Rset = 30;
    expect_out("z_r0_stored", S_A_Z, 0);
    expect_out("z_r30_stored", S_B_Z, 0);
    expect_out("z_r0_busy_next", S_YA_Z, 0);
    drain();
    next_cycle();
    Rb = 30; wr0(23, 32'h00000017, 4'hF); Ra = 23;
    expect_out("z_r30_busy", S_YB_Z, 0);
    expect_out("z_r23_last", S_A_Z, 32'h17);
    drain();
    next_cycle();

    // Randomised traffic against a reference model, from a fresh reset
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int r = 0; r < 32; r++) m[r] = 0;
    pend = 0;
    for (int k = 0; k < 300; k++) begin
      logic setA, clrA, setB, clrB;
      RegWr0 = 1'($urandom_range(0, 1)); Rw0 = 5'($urandom_range(0, 7));
      busW0 = $urandom; ByteEn0 = 4'($urandom_range(0, 15));
      RegWr1 = 1'($urandom_range(0, 1)); Rw1 = 5'($urandom_range(0, 7));
      busW1 = $urandom; ByteEn1 = 4'($urandom_range(0, 15));
      Rset_en = 1'($urandom_range(0, 1)); Rset = 5'($urandom_range(0, 7));
      Ra = 5'($urandom_range(0, 7)); Rb = 5'($urandom_range(0, 7));
      for (int r = 0; r < 32; r++) mn[r] = m[r];
      for (int b = 0; b < 4; b++) begin
        if (RegWr0 && Rw0 != 0 && ByteEn0[b]) mn[Rw0][8*b +: 8] = busW0[8*b +: 8];
        if (RegWr1 && Rw1 != 0 && ByteEn1[b]) mn[Rw1][8*b +: 8] = busW1[8*b +: 8];
      end
      setA = Rset_en && Rset == Ra && Ra != 0;
      setB = Rset_en && Rset == Rb && Rb != 0;
      clrA = Ra != 0 && ((RegWr0 && Rw0 == Ra && ByteEn0 != 0) || (RegWr1 && Rw1 == Ra && ByteEn1 != 0));
      clrB = Rb != 0 && ((RegWr0 && Rw0 == Rb && ByteEn0 != 0) || (RegWr1 && Rw1 == Rb && ByteEn1 != 0));
      expect_out("rnd_busA_b", S_A_B, mn[Ra]);
      expect_out("rnd_busB_b", S_B_B, mn[Rb]);
      expect_out("rnd_busA_nb", S_A_NB, m[Ra]);
      expect_out("rnd_busyA_b", S_YA_B, {31'd0, pend[Ra] && !(clrA && !setA)});
      expect_out("rnd_busyB_b", S_YB_B, {31'd0, pend[Rb] && !(clrB && !setB)});
      expect_out("rnd_busyA_nb", S_YA_NB, {31'd0, pend[Ra]});
      drain();
      for (int r = 1; r < 32; r++) begin
        if (Rset_en && Rset == 5'(r)) pend[r] = 1'b1;
        else if ((RegWr0 && Rw0 == 5'(r) && ByteEn0 != 0) ||
                 (RegWr1 && Rw1 == 5'(r) && ByteEn1 != 0)) pend[r] = 1'b0;
      end
      for (int r = 0; r < 32; r++) m[r] = mn[r];
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
